// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory controller:
//   - state_e      : controller state (INIT = RAM clear sequence, RUN = bus live)
//   - RES_OFS      : result-port address offset above the RAM window (DEPTH+0)
//   - CNT_OFS      : cycle-counter address offset above the RAM window (DEPTH+1)
//   - PRELOAD0/1   : values written to RAM[0]/RAM[1] when DMEM_PRELOAD_EN is set
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int RES_OFS  = 0;
   localparam int CNT_OFS  = 1;

   localparam int PRELOAD0 = 5;
   localparam int PRELOAD1 = 50;

endpackage

// File: rtl/dmem_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// CPU-side control signals of the data-memory bus.
//   DA    : 16-bit data address        (master -> slave)
//   RW    : 1 = read, 0 = write        (master -> slave)
//   READY : memory initialised, bus live (slave -> master)
// The bidirectional data bus DD is a plain inout port of dmem_ctrl so that
// the tristate net is resolved at module level.
// -----------------------------------------------------------------------------
interface dmem_if;

   logic [15:0] DA;
   logic        RW;
   logic        READY;

   modport master (output DA, output RW, input  READY);
   modport slave  (input  DA, input  RW, output READY);

endinterface

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// DEPTH x WIDTH storage array, one write port and one asynchronous read port.
// Writes take effect on the falling edge of CK.
//   CK      : clock (falling edge active)
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
// Contents are not reset; the controller clears them with its INIT sequence.
// -----------------------------------------------------------------------------
module dmem_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             CK,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(negedge CK) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller: clears the RAM after reset, then serves CPU reads
// and writes to RAM, a result-port register and a free-running cycle counter.
// All state changes on the falling edge of CK (CPU launches on rising edge).
//   CK    : clock
//   RST   : asynchronous active-low reset
//   bus   : dmem_if.slave (DA, RW in; READY out)
//   DD    : bidirectional data bus, driven only for reads while READY
//   OUT   : result-port register
//   DONE  : sticky, set by the first store to the result port
// Address map: DA < DEPTH -> RAM, DEPTH -> result port, DEPTH+1 -> counter
// (read-only), everything else unmapped (reads 0, writes ignored).
// Build option: define DMEM_PRELOAD_EN to have INIT write RAM[0]=5 and
// RAM[1]=50 instead of 0; INIT duration is the same either way.
// -----------------------------------------------------------------------------
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 128
) (
   input  logic             CK,
   input  logic             RST,
   dmem_if.slave            bus,
   inout  wire  [WIDTH-1:0] DD,
   output logic [WIDTH-1:0] OUT,
   output logic             DONE
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q, state_d;
   logic [AW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] rd_q, rd_d;

   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic [WIDTH-1:0] ram_wdata;
   logic [WIDTH-1:0] ram_rdata;

   logic             ready;
   logic             is_ram, is_res, is_cnt;

`ifdef DMEM_PRELOAD_EN
   function automatic logic [WIDTH-1:0] preload_word(input logic [AW-1:0] a);
      logic [WIDTH-1:0] w;
      w = '0;
      if (a == AW'(0))      w = WIDTH'(PRELOAD0);
      else if (a == AW'(1)) w = WIDTH'(PRELOAD1);
      return w;
   endfunction
`endif

   // Full 16-bit compare so that e.g. DA=130 does not alias onto RAM[2].
   assign is_ram = (32'(bus.DA) <  32'(DEPTH));
   assign is_res = (32'(bus.DA) == 32'(DEPTH + RES_OFS));
   assign is_cnt = (32'(bus.DA) == 32'(DEPTH + CNT_OFS));

   assign ready     = (state_q == RUN);
   assign bus.READY = ready;
   assign OUT       = out_q;
   assign DONE      = done_q;

   // Read register drives the bus continuously: one-falling-edge read latency.
   assign DD = (bus.RW && ready) ? rd_q : {WIDTH{1'bz}};

   dmem_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .CK      (CK),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (bus.DA[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      done_d    = done_q;
      rd_d      = rd_q;
      ram_we    = 1'b0;
      ram_waddr = bus.DA[AW-1:0];
      ram_wdata = DD;

      case (state_q)
         INIT: begin
            // Bus is ignored; sweep the pointer over every word once.
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
`ifdef DMEM_PRELOAD_EN
            ram_wdata = preload_word(ptr_q);
`else
            ram_wdata = '0;
`endif
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) state_d = RUN;
         end
         RUN: begin
            cnt_d = cnt_q + WIDTH'(1);
            if (bus.RW) begin
               if (is_ram)      rd_d = ram_rdata;
               else if (is_res) rd_d = out_q;
               else if (is_cnt) rd_d = cnt_q;
               else             rd_d = '0;
            end else begin
               if (is_ram) begin
                  ram_we = 1'b1;
               end else if (is_res) begin
                  out_d  = DD;
                  done_d = 1'b1;
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(negedge CK or negedge RST) begin
      if (!RST) begin
         state_q <= INIT;
         ptr_q   <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Directed testbench for dmem_ctrl. Inputs are changed 1 time unit after each
// falling edge and outputs sampled at that same point, so every value seen
// reflects the falling edge just taken. Expected values follow the
// DMEM_PRELOAD_EN build option.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 128;

`ifdef DMEM_PRELOAD_EN
   localparam logic [15:0] EXP_W0 = 16'd5;
   localparam logic [15:0] EXP_W1 = 16'd50;
`else
   localparam logic [15:0] EXP_W0 = 16'd0;
   localparam logic [15:0] EXP_W1 = 16'd0;
`endif

   logic              CK = 1'b0;
   logic              RST;
   logic              tb_oe;
   logic [WIDTH-1:0]  tb_dd;
   wire  [WIDTH-1:0]  DD;
   logic [WIDTH-1:0]  OUT;
   logic              DONE;

   int checks = 0;
   int errors = 0;

   dmem_if bus ();

   assign DD = tb_oe ? tb_dd : {WIDTH{1'bz}};

   dmem_ctrl #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .CK   (CK),
      .RST  (RST),
      .bus  (bus),
      .DD   (DD),
      .OUT  (OUT),
      .DONE (DONE)
   );

   always #5 CK = ~CK;

   task automatic step();
      @(negedge CK);
      #1;
   endtask

   task automatic test_reset();
      RST    = 1'b0;
      tb_oe  = 1'b0;
      tb_dd  = '0;
      bus.DA = '0;
      bus.RW = 1'b1;
      #100;
      checks++;
      if (bus.READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.READY); end
      checks++;
      if (OUT !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", OUT); end
      checks++;
      if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DONE); end
      @(posedge CK);
      #2;
      RST = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         if (i == DEPTH - 1) begin
            checks++;
            if (bus.READY !== 1'b0) begin errors++; $display("FAIL init_ready_127: got %b expected 0", bus.READY); end
         end
      end
      checks++;
      if (bus.READY !== 1'b1) begin errors++; $display("FAIL init_ready_128: got %b expected 1", bus.READY); end
      checks++;
      if (OUT !== 16'h0000 || DONE !== 1'b0) begin
         errors++; $display("FAIL init_out_done: got %h/%b expected 0000/0", OUT, DONE);
      end
   endtask

   task automatic test_preload();
      bus.RW = 1'b1;
      bus.DA = 16'd0;
      step();
      checks++;
      if (DD !== EXP_W0) begin errors++; $display("FAIL preload_w0: got %h expected %h", DD, EXP_W0); end
      bus.DA = 16'd1;
      step();
      checks++;
      if (DD !== EXP_W1) begin errors++; $display("FAIL preload_w1: got %h expected %h", DD, EXP_W1); end
   endtask

   task automatic test_write_read();
      bus.RW = 1'b0; bus.DA = 16'd5; tb_dd = 16'h1234; tb_oe = 1'b1;
      step();
      bus.RW = 1'b1; tb_oe = 1'b0;
      step();
      checks++;
      if (DD !== 16'h1234) begin errors++; $display("FAIL raw_da5: got %h expected 1234", DD); end
      bus.DA = 16'd200;
      step();
      checks++;
      if (DD !== 16'h0000) begin errors++; $display("FAIL unmapped_200: got %h expected 0000", DD); end
      bus.RW = 1'b0; bus.DA = 16'd127; tb_dd = 16'hA5A5; tb_oe = 1'b1;
      step();
      bus.RW = 1'b1; tb_oe = 1'b0;
      step();
      checks++;
      if (DD !== 16'hA5A5) begin errors++; $display("FAIL raw_da127: got %h expected a5a5", DD); end
      bus.DA = 16'd6;
      step();
      checks++;
      if (DD !== 16'h0000) begin errors++; $display("FAIL untouched_da6: got %h expected 0000", DD); end
   endtask

   task automatic test_result_port();
      bus.RW = 1'b0; bus.DA = 16'd128; tb_dd = 16'h0100; tb_oe = 1'b1;
      step();
      checks++;
      if (OUT !== 16'h0100 || DONE !== 1'b1) begin
         errors++; $display("FAIL store1: got %h/%b expected 0100/1", OUT, DONE);
      end
      tb_dd = 16'h0004;
      step();
      checks++;
      if (OUT !== 16'h0004 || DONE !== 1'b1) begin
         errors++; $display("FAIL store2: got %h/%b expected 0004/1", OUT, DONE);
      end
      bus.DA = 16'd130; tb_dd = 16'hDEAD;
      step();
      checks++;
      if (OUT !== 16'h0004) begin errors++; $display("FAIL unmapped_wr_out: got %h expected 0004", OUT); end
      bus.RW = 1'b1; bus.DA = 16'd128; tb_oe = 1'b0;
      step();
      checks++;
      if (DD !== 16'h0004) begin errors++; $display("FAIL read_res: got %h expected 0004", DD); end
      bus.DA = 16'd2;
      step();
      checks++;
      if (DD !== 16'h0000) begin errors++; $display("FAIL no_alias_da2: got %h expected 0000", DD); end
   endtask

   task automatic test_counter();
      logic [15:0] c0;
      logic [15:0] c1;
      bit          hit;
      bus.RW = 1'b1; bus.DA = 16'd129; tb_oe = 1'b0;
      step();
      c0 = DD;
      repeat (10) step();
      c1 = DD;
      checks++;
      if (16'(c1 - c0) !== 16'd10) begin
         errors++; $display("FAIL cnt_delta: got %h expected 000a", 16'(c1 - c0));
      end
      hit = 1'b0;
      for (int i = 0; i < 70000 && !hit; i++) begin
         step();
         if (DD === 16'hFFFF) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL cnt_reach_ffff: got %h expected ffff within bound", DD);
      end else begin
         step();
         checks++;
         if (DD !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000", DD); end
      end
   endtask

   task automatic test_reinit();
      bus.RW = 1'b0; bus.DA = 16'd0; tb_dd = 16'h7777; tb_oe = 1'b1;
      step();
      bus.RW = 1'b1; tb_oe = 1'b0;
      // reset from RUN, then abort the first INIT at pointer 60
      RST = 1'b0;
      #20;
      @(posedge CK);
      #2;
      RST = 1'b1;
      repeat (60) step();
      RST = 1'b0;
      #20;
      checks++;
      if (bus.READY !== 1'b0 || OUT !== 16'h0000 || DONE !== 1'b0) begin
         errors++; $display("FAIL midinit_reset: got %b/%h/%b expected 0/0000/0", bus.READY, OUT, DONE);
      end
      @(posedge CK);
      #2;
      RST = 1'b1;
      bus.RW = 1'b0; bus.DA = 16'd3; tb_dd = 16'hBEEF; tb_oe = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         if (i == 100) bus.DA = 16'd128;
         if (i == 120) begin bus.RW = 1'b1; bus.DA = 16'd129; tb_oe = 1'b0; end
         if (i == DEPTH - 1) begin
            checks++;
            if (bus.READY !== 1'b0) begin errors++; $display("FAIL reinit_ready_127: got %b expected 0", bus.READY); end
         end
      end
      checks++;
      if (bus.READY !== 1'b1) begin errors++; $display("FAIL reinit_ready_128: got %b expected 1", bus.READY); end
      checks++;
      if (OUT !== 16'h0000 || DONE !== 1'b0) begin
         errors++; $display("FAIL init_writes_ignored: got %h/%b expected 0000/0", OUT, DONE);
      end
      step();
      checks++;
      if (DD !== 16'h0000) begin errors++; $display("FAIL cnt_first_run: got %h expected 0000", DD); end
      step();
      checks++;
      if (DD !== 16'h0001) begin errors++; $display("FAIL cnt_second_run: got %h expected 0001", DD); end
      bus.DA = 16'd3;
      step();
      checks++;
      if (DD !== 16'h0000) begin errors++; $display("FAIL init_write_da3: got %h expected 0000", DD); end
      bus.DA = 16'd0;
      step();
      checks++;
      if (DD !== EXP_W0) begin errors++; $display("FAIL reinit_w0: got %h expected %h", DD, EXP_W0); end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_write_read();
      test_result_port();
      test_counter();
      test_reinit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
